stack_seq: RTL and testbench
============================

Name: stack_seq

Overview:
- Initiator (master) side of the ss_io stack bus.
- Accepts Forth stack-primitive commands over a valid/ready handshake.
- Keeps TOS in a local register and issues PUSH/POP sequences to the downstream EBR stack.
- Sits between the instruction decoder and the data stack, and tracks depth, underflow and overflow.

Parameters:
- DEPTH, 64: entries in downstream stack RAM; max items held = DEPTH+1 (TOS reg + RAM).
- DSZ, 32: data width.
- DW, $clog2(DEPTH+2): width of depth counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  enable; low = freeze all state, ss_op=NOP, cmd_ready=0
- cmd_valid  in  1  command strobe
- cmd_ready  out  1  = en && state==IDLE
- cmd_op  in  3  0 NOP, 1 LIT, 2 DUP, 3 DROP, 4 SWAP, 5 OVER, 6 ADD, 7 ROT
- cmd_lit  in  DSZ  literal for LIT
- ss_op  out  2  stack bus op: NOP 00, PUSH 01, POP 10 (PICK 11 never driven)
- ss_vi  out  DSZ  stack bus write data
- ss_s  in  DSZ  stack bus read data; valid combinationally in the same cycle as POP
- tos  out  DSZ  top-of-stack register
- depth  out  DW  total items (TOS + RAM)
- busy  out  1  state != IDLE
- err_under  out  1  sticky underflow flag
- err_over  out  1  sticky overflow flag

Behaviour:
- Reset: tos=0, depth=0, state=IDLE, err_*=0, ss_op=NOP, ss_vi=0. Mid-sequence reset aborts the sequence; the downstream stack shares rst.
- Accept: a command is taken on a clk edge with cmd_valid && cmd_ready.
  - Single-cycle ops drive ss_op in the accept cycle, combinationally from cmd_op.
  - Multi-cycle ops drive step 1 in the accept cycle and continue in states.
- Stack bus contract: PUSH writes ss_vi at the edge. POP returns NOS on ss_s in that cycle; the sequencer captures it at the edge.
- NOP: no bus activity.
- LIT: if depth>0, PUSH tos. tos<=cmd_lit; depth+1.
- DUP: requires depth>=1. PUSH tos; depth+1.
- DROP: requires depth>=1.
  - depth==1: tos<=0, no bus op.
  - Else: POP, tos<=ss_s.
  - depth-1.
- ADD: requires depth>=2. POP; tos<=ss_s+tos mod 2^DSZ; depth-1.
- SWAP: requires depth>=2.
  - IDLE: POP, tmp<=ss_s.
  - SWAP2: PUSH tos, tos<=tmp.
  - 2 cycles.
- OVER: requires depth>=2.
  - IDLE: POP, tmp<=ss_s.
  - OVER2: PUSH tmp.
  - OVER3: PUSH tos, tos<=tmp, depth+1.
  - 3 cycles.
- Overflow: any op that would make depth > DEPTH+1 sets err_over. The command is consumed with no side effects.
- Underflow: any op whose depth requirement fails sets err_under. The command is consumed with no side effects.
- Errors are checked at accept only.
- Depth updates at the final step of each op.
- tos is visible one cycle after the final step.
- Simultaneous events:
  - cmd_valid while busy is ignored (not accepted).
  - en low mid-sequence holds the state and step, and resumes when en returns.
  - err flags clear only on rst.
- Wrap: depth never wraps, enforced by the overflow check.

Optional Feature:
STACK_SEQ_ROT_EN:
- With the macro: opcode 7 = ROT (a b c -- b c a), requires depth>=3.
  - IDLE: POP t1<=b.
  - ROT2: POP t2<=a.
  - ROT3: PUSH t1.
  - ROT4: PUSH tos, tos<=t2.
  - 4 cycles, depth unchanged.
- Without the macro: opcode 7 behaves as NOP. No ROT states or t2 register are synthesized.

Test Plan:
- Reset then LIT 5, LIT 7, ADD -> tos=12, depth=1, ss_op sequence NOP, PUSH(5), POP; err flags 0.
- LIT 1, LIT 2, SWAP -> tos=1, next DROP yields tos=2. SWAP holds busy=1 for 1 extra cycle and cmd_ready=0 during that cycle.
- LIT 3, LIT 4, OVER -> depth=3; successive DROPs yield tos 3, 4, 3, then 0 at depth 0.
- DROP at depth 0 -> err_under=1, tos=0, depth=0, no ss_op. A subsequent LIT 9 still works (tos=9).
- DEPTH+1 LITs then DUP -> err_over=1, depth stays DEPTH+1, no PUSH issued. Assert rst mid-OVER -> all outputs return to reset values immediately.
- With STACK_SEQ_ROT_EN: LIT 1, 2, 3, ROT -> pops give 1 (tos), then 3, then 2. Without the macro: ROT leaves tos=3, depth=3.

Source files
------------

// File: rtl/stack_seq.sv
// stack_seq: Forth stack-primitive sequencer; keeps TOS locally and drives PUSH/POP on the ss_io bus.
// Define STACK_SEQ_ROT_EN to implement ROT on opcode 7 (otherwise opcode 7 is a NOP).
module stack_seq #(
  parameter int DEPTH = 64,
  parameter int DSZ   = 32,
  parameter int DW    = $clog2(DEPTH + 2)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [2:0]     cmd_op,
  input  logic [DSZ-1:0] cmd_lit,
  output logic [1:0]     ss_op,
  output logic [DSZ-1:0] ss_vi,
  input  logic [DSZ-1:0] ss_s,
  output logic [DSZ-1:0] tos,
  output logic [DW-1:0]  depth,
  output logic           busy,
  output logic           err_under,
  output logic           err_over
);

  typedef enum logic [2:0] {
    OP_NOP, OP_LIT, OP_DUP, OP_DROP, OP_SWAP, OP_OVER, OP_ADD, OP_ROT
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE, S_SWAP2, S_OVER2, S_OVER3
`ifdef STACK_SEQ_ROT_EN
    , S_ROT2, S_ROT3, S_ROT4
`endif
  } state_e;

  localparam logic [1:0]    BUS_NOP   = 2'b00;
  localparam logic [1:0]    BUS_PUSH  = 2'b01;
  localparam logic [1:0]    BUS_POP   = 2'b10;
  localparam logic [DW-1:0] MAX_DEPTH = DW'(DEPTH + 1);
  localparam logic [DW-1:0] D_ONE     = DW'(1);
  localparam logic [DW-1:0] D_TWO     = DW'(2);

  state_e         r_state, w_state_nxt;
  logic [DSZ-1:0] r_tos, w_tos_nxt;
  logic [DSZ-1:0] r_tmp, w_tmp_nxt;
  logic [DW-1:0]  r_depth, w_depth_nxt;
  logic           r_err_under, r_err_over;
  logic           w_under_set, w_over_set;
  logic [1:0]     w_ss_op;
  logic [DSZ-1:0] w_ss_vi;
  logic           w_empty, w_lt2, w_full;
`ifdef STACK_SEQ_ROT_EN
  logic [DSZ-1:0] r_t2, w_t2_nxt;
  logic           w_lt3;
  assign w_lt3 = (r_depth < DW'(3));
`endif

  assign w_empty = (r_depth == '0);
  assign w_lt2   = (r_depth < D_TWO);
  assign w_full  = (r_depth == MAX_DEPTH);

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_tos_nxt   = r_tos;
    w_tmp_nxt   = r_tmp;
    w_depth_nxt = r_depth;
    w_under_set = 1'b0;
    w_over_set  = 1'b0;
    w_ss_op     = BUS_NOP;
    w_ss_vi     = '0;
`ifdef STACK_SEQ_ROT_EN
    w_t2_nxt    = r_t2;
`endif
    if (en) begin
      case (r_state)
        S_IDLE: if (cmd_valid) begin
          case (op_e'(cmd_op))
            OP_LIT: if (w_full) w_over_set = 1'b1;
              else begin
                if (!w_empty) begin
                  w_ss_op = BUS_PUSH;
                  w_ss_vi = r_tos;
                end
                w_tos_nxt   = cmd_lit;
                w_depth_nxt = r_depth + D_ONE;
              end
            OP_DUP: if (w_empty) w_under_set = 1'b1;
              else if (w_full) w_over_set = 1'b1;
              else begin
                w_ss_op     = BUS_PUSH;
                w_ss_vi     = r_tos;
                w_depth_nxt = r_depth + D_ONE;
              end
            OP_DROP: if (w_empty) w_under_set = 1'b1;
              else begin
                // The last item lives only in the TOS register, so it is cleared without a bus pop.
                if (r_depth == D_ONE) w_tos_nxt = '0;
                else begin
                  w_ss_op   = BUS_POP;
                  w_tos_nxt = ss_s;
                end
                w_depth_nxt = r_depth - D_ONE;
              end
            OP_ADD: if (w_lt2) w_under_set = 1'b1;
              else begin
                w_ss_op     = BUS_POP;
                w_tos_nxt   = ss_s + r_tos;
                w_depth_nxt = r_depth - D_ONE;
              end
            OP_SWAP: if (w_lt2) w_under_set = 1'b1;
              else begin
                w_ss_op     = BUS_POP;
                w_tmp_nxt   = ss_s;
                w_state_nxt = S_SWAP2;
              end
            OP_OVER: if (w_lt2) w_under_set = 1'b1;
              else if (w_full) w_over_set = 1'b1;
              else begin
                w_ss_op     = BUS_POP;
                w_tmp_nxt   = ss_s;
                w_state_nxt = S_OVER2;
              end
`ifdef STACK_SEQ_ROT_EN
            OP_ROT: if (w_lt3) w_under_set = 1'b1;
              else begin
                w_ss_op     = BUS_POP;
                w_tmp_nxt   = ss_s;
                w_state_nxt = S_ROT2;
              end
`endif
            default: ;
          endcase
        end
        S_SWAP2: begin
          w_ss_op     = BUS_PUSH;
          w_ss_vi     = r_tos;
          w_tos_nxt   = r_tmp;
          w_state_nxt = S_IDLE;
        end
        S_OVER2: begin
          w_ss_op     = BUS_PUSH;
          w_ss_vi     = r_tmp;
          w_state_nxt = S_OVER3;
        end
        S_OVER3: begin
          w_ss_op     = BUS_PUSH;
          w_ss_vi     = r_tos;
          w_tos_nxt   = r_tmp;
          w_depth_nxt = r_depth + D_ONE;
          w_state_nxt = S_IDLE;
        end
`ifdef STACK_SEQ_ROT_EN
        S_ROT2: begin
          w_ss_op     = BUS_POP;
          w_t2_nxt    = ss_s;
          w_state_nxt = S_ROT3;
        end
        S_ROT3: begin
          w_ss_op     = BUS_PUSH;
          w_ss_vi     = r_tmp;
          w_state_nxt = S_ROT4;
        end
        S_ROT4: begin
          w_ss_op     = BUS_PUSH;
          w_ss_vi     = r_tos;
          w_tos_nxt   = r_t2;
          w_state_nxt = S_IDLE;
        end
`endif
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_tos       <= '0;
      r_tmp       <= '0;
      r_depth     <= '0;
      r_err_under <= 1'b0;
      r_err_over  <= 1'b0;
`ifdef STACK_SEQ_ROT_EN
      r_t2        <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_tos       <= w_tos_nxt;
      r_tmp       <= w_tmp_nxt;
      r_depth     <= w_depth_nxt;
      r_err_under <= r_err_under | w_under_set;
      r_err_over  <= r_err_over | w_over_set;
`ifdef STACK_SEQ_ROT_EN
      r_t2        <= w_t2_nxt;
`endif
    end
  end

  assign cmd_ready = en && (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign ss_op     = w_ss_op;
  assign ss_vi     = w_ss_vi;
  assign tos       = r_tos;
  assign depth     = r_depth;
  assign err_under = r_err_under;
  assign err_over  = r_err_over;

endmodule

// File: tb/tb_stack_seq.sv
// Self-checking bench for stack_seq: directed test-plan steps plus random commands against a queue model.
// A behavioural downstream stack RAM answers the ss_io bus.
module tb_stack_seq;
  localparam int TB_DEPTH = 8;
  localparam int TB_DSZ   = 32;
  localparam int TB_DW    = $clog2(TB_DEPTH + 2);
  localparam int MAXD     = TB_DEPTH + 1;

  localparam logic [2:0] C_NOP = 3'd0, C_LIT = 3'd1, C_DUP = 3'd2, C_DROP = 3'd3;
  localparam logic [2:0] C_SWAP = 3'd4, C_OVER = 3'd5, C_ADD = 3'd6, C_ROT = 3'd7;
  localparam logic [1:0] B_NOP = 2'b00, B_PUSH = 2'b01, B_POP = 2'b10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [2:0]        cmd_op = C_NOP;
  logic [TB_DSZ-1:0] cmd_lit = '0;
  logic [1:0]        ss_op;
  logic [TB_DSZ-1:0] ss_vi;
  logic [TB_DSZ-1:0] ss_s;
  logic [TB_DSZ-1:0] tos;
  logic [TB_DW-1:0]  depth;
  logic              busy, err_under, err_over;

  always #5 clk = ~clk;

  stack_seq #(.DEPTH(TB_DEPTH), .DSZ(TB_DSZ)) dut (
    .clk(clk), .rst(rst), .en(en), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_lit(cmd_lit), .ss_op(ss_op), .ss_vi(ss_vi), .ss_s(ss_s),
    .tos(tos), .depth(depth), .busy(busy), .err_under(err_under), .err_over(err_over)
  );

  // Downstream stack RAM: PUSH writes at the edge, POP data is the current top.
  logic [TB_DSZ-1:0] ram [TB_DEPTH];
  int                ram_cnt = 0;
  int                push_cnt = 0, pop_cnt = 0, bus_err = 0;
  logic [TB_DSZ-1:0] last_push = '0;

  assign ss_s = (ram_cnt > 0) ? ram[ram_cnt-1] : '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_cnt <= 0;
    end else if (ss_op == B_PUSH) begin
      if (ram_cnt >= TB_DEPTH) bus_err <= bus_err + 1;
      else begin
        ram[ram_cnt] <= ss_vi;
        ram_cnt      <= ram_cnt + 1;
      end
      push_cnt  <= push_cnt + 1;
      last_push <= ss_vi;
    end else if (ss_op == B_POP) begin
      if (ram_cnt == 0) bus_err <= bus_err + 1;
      else ram_cnt <= ram_cnt - 1;
      pop_cnt <= pop_cnt + 1;
    end else if (ss_op != B_NOP) begin
      bus_err <= bus_err + 1;
    end
  end

  // Reference model: the whole Forth stack as a queue, back element is TOS.
  logic [TB_DSZ-1:0] mq[$];
  logic              m_under = 1'b0, m_over = 1'b0;
  int                n_cmp = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_apply(input logic [2:0] op, input logic [TB_DSZ-1:0] lit,
                                      output int ep, output int eo);
    int n;
    logic [TB_DSZ-1:0] a, b, c;
    n = mq.size();
    ep = 0;
    eo = 0;
    case (op)
      C_LIT: if (n == MAXD) m_over = 1'b1;
        else begin ep = (n > 0) ? 1 : 0; mq.push_back(lit); end
      C_DUP: if (n < 1) m_under = 1'b1;
        else if (n == MAXD) m_over = 1'b1;
        else begin ep = 1; mq.push_back(mq[n-1]); end
      C_DROP: if (n < 1) m_under = 1'b1;
        else begin eo = (n > 1) ? 1 : 0; a = mq.pop_back(); end
      C_ADD: if (n < 2) m_under = 1'b1;
        else begin eo = 1; a = mq.pop_back(); b = mq.pop_back(); mq.push_back(a + b); end
      C_SWAP: if (n < 2) m_under = 1'b1;
        else begin ep = 1; eo = 1; a = mq[n-1]; mq[n-1] = mq[n-2]; mq[n-2] = a; end
      C_OVER: if (n < 2) m_under = 1'b1;
        else if (n == MAXD) m_over = 1'b1;
        else begin ep = 2; eo = 1; mq.push_back(mq[n-2]); end
`ifdef STACK_SEQ_ROT_EN
      C_ROT: if (n < 3) m_under = 1'b1;
        else begin
          ep = 2; eo = 2;
          c = mq.pop_back(); b = mq.pop_back(); a = mq.pop_back();
          mq.push_back(b); mq.push_back(c); mq.push_back(a);
        end
`endif
      default: ;
    endcase
  endfunction

  function automatic logic [TB_DSZ-1:0] m_tos();
    return (mq.size() > 0) ? mq[mq.size()-1] : '0;
  endfunction

  task automatic check_state(input string tag);
    int bad, n_ram;
    bad = 0;
    n_ram = (mq.size() > 0) ? mq.size() - 1 : 0;
    check({tag, "/tos"}, tos, m_tos());
    check({tag, "/depth"}, depth, mq.size());
    check({tag, "/err_under"}, err_under, m_under);
    check({tag, "/err_over"}, err_over, m_over);
    check({tag, "/busy"}, busy, 0);
    check({tag, "/ram_cnt"}, ram_cnt, n_ram);
    for (int i = 0; i < n_ram && i < ram_cnt; i++) if (ram[i] !== mq[i]) bad++;
    check({tag, "/ram_data"}, bad, 0);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 10 && busy; i++) @(negedge clk);
    check({tag, "/idle"}, busy, 0);
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [TB_DSZ-1:0] lit, input string tag);
    int p0, o0, ep, eo;
    @(negedge clk);
    check({tag, "/ready"}, cmd_ready, 1);
    p0 = push_cnt;
    o0 = pop_cnt;
    cmd_valid = 1'b1; cmd_op = op; cmd_lit = lit;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = C_NOP; cmd_lit = '0;
    wait_idle(tag);
    model_apply(op, lit, ep, eo);
    check_state(tag);
    check({tag, "/pushes"}, push_cnt - p0, ep);
    check({tag, "/pops"}, pop_cnt - o0, eo);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b1; cmd_valid = 1'b0; cmd_op = C_NOP; cmd_lit = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_under = 1'b0;
    m_over = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, o0, ep, eo;

    // Reset state, then LIT 5, LIT 7, ADD.
    do_reset();
    check_state("reset");
    check("reset/ss_op", ss_op, B_NOP);
    check("reset/ss_vi", ss_vi, 0);
    check("reset/ready", cmd_ready, 1);
    do_cmd(C_LIT, 32'd5, "t1_lit5");
    do_cmd(C_LIT, 32'd7, "t1_lit7");
    check("t1/pushed_val", last_push, 32'd5);
    do_cmd(C_ADD, 32'd0, "t1_add");
    check("t1/sum", tos, 32'd12);
    check("t1/depth", depth, 1);

    // SWAP: busy for one extra cycle; a command offered meanwhile is ignored.
    do_reset();
    do_cmd(C_LIT, 32'd1, "t2_lit1");
    do_cmd(C_LIT, 32'd2, "t2_lit2");
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = C_SWAP;
    @(negedge clk);
    check("t2/swap_busy", busy, 1);
    check("t2/swap_ready", cmd_ready, 0);
    cmd_op = C_LIT; cmd_lit = 32'd99;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = C_NOP; cmd_lit = '0;
    check("t2/swap_done", busy, 0);
    model_apply(C_SWAP, 32'd0, ep, eo);
    check_state("t2_swap");
    check("t2/tos_after_swap", tos, 32'd1);
    do_cmd(C_DROP, 32'd0, "t2_drop");
    check("t2/tos_after_drop", tos, 32'd2);

    // OVER, then drain with DROPs down to depth 0.
    do_reset();
    do_cmd(C_LIT, 32'd3, "t3_lit3");
    do_cmd(C_LIT, 32'd4, "t3_lit4");
    do_cmd(C_OVER, 32'd0, "t3_over");
    check("t3/depth", depth, 3);
    check("t3/tos", tos, 32'd3);
    do_cmd(C_DROP, 32'd0, "t3_drop1");
    check("t3/drop1", tos, 32'd4);
    do_cmd(C_DROP, 32'd0, "t3_drop2");
    check("t3/drop2", tos, 32'd3);
    do_cmd(C_DROP, 32'd0, "t3_drop3");
    check("t3/drop3", tos, 32'd0);

    // Underflow on empty stack, then normal operation continues.
    do_cmd(C_DROP, 32'd0, "t4_under");
    check("t4/err_under", err_under, 1);
    do_cmd(C_LIT, 32'd9, "t4_lit9");
    check("t4/tos", tos, 32'd9);
    check("t4/sticky", err_under, 1);

    // Fill to DEPTH+1, then DUP/LIT/OVER overflow with no bus traffic.
    do_reset();
    for (int i = 0; i < MAXD; i++) do_cmd(C_LIT, 32'(100 + i), "t5_fill");
    check("t5/full_depth", depth, MAXD);
    do_cmd(C_DUP, 32'd0, "t5_dup_over");
    check("t5/err_over", err_over, 1);
    check("t5/err_under", err_under, 0);
    do_cmd(C_LIT, 32'd1, "t5_lit_over");
    do_cmd(C_OVER, 32'd0, "t5_over_over");
    check("t5/depth_kept", depth, MAXD);

    // en low mid-OVER holds the sequence; it resumes when en returns.
    do_reset();
    do_cmd(C_LIT, 32'hA, "t6_lita");
    do_cmd(C_LIT, 32'hB, "t6_litb");
    @(negedge clk);
    p0 = push_cnt; o0 = pop_cnt;
    cmd_valid = 1'b1; cmd_op = C_OVER;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = C_NOP;
    en = 1'b0;
    #1;
    check("t6/hold_ss_op", ss_op, B_NOP);
    check("t6/hold_ready", cmd_ready, 0);
    repeat (3) @(negedge clk);
    check("t6/hold_busy", busy, 1);
    check("t6/hold_pushes", push_cnt - p0, 0);
    en = 1'b1;
    wait_idle("t6_resume");
    model_apply(C_OVER, 32'd0, ep, eo);
    check_state("t6_over");
    check("t6/pushes", push_cnt - p0, ep);
    check("t6/pops", pop_cnt - o0, eo);

    // Reset asserted mid-OVER returns outputs to reset values at once.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = C_OVER;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = C_NOP;
    check("t7/mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("t7/tos", tos, 0);
    check("t7/depth", depth, 0);
    check("t7/busy", busy, 0);
    check("t7/ss_op", ss_op, B_NOP);
    check("t7/ss_vi", ss_vi, 0);
    check("t7/errs", {err_under, err_over}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_under = 1'b0;
    m_over = 1'b0;
    check_state("t7_after");

    // ROT (or NOP when the option is absent).
    do_cmd(C_LIT, 32'd1, "t8_lit1");
    do_cmd(C_LIT, 32'd2, "t8_lit2");
    do_cmd(C_LIT, 32'd3, "t8_lit3");
    do_cmd(C_ROT, 32'd0, "t8_rot");
`ifdef STACK_SEQ_ROT_EN
    check("t8/rot_tos", tos, 32'd1);
    do_cmd(C_DROP, 32'd0, "t8_drop1");
    check("t8/drop1", tos, 32'd3);
    do_cmd(C_DROP, 32'd0, "t8_drop2");
    check("t8/drop2", tos, 32'd2);
`else
    check("t8/rot_tos", tos, 32'd3);
    check("t8/rot_depth", depth, 3);
`endif

    // Random commands against the queue model.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) op = C_LIT;
      do_cmd(op, $urandom, "rnd");
    end

    check("bus_protocol", bus_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
